// File: rtl/rv32_writeback_unit_if.sv
// Bundle of the writeback unit's pipeline-facing signals: ALU results, load issue,
// memory responses, and the register-file write port with hazard outputs.
interface rv32_writeback_unit_if;
    // Handshakes: a transfer happens on a posedge where valid && ready are both 1.
    // ready depends only on registered occupancy. mem_rvalid has no ready and is always taken.
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [1:0]  ld_issue_addr_lo;
    logic        ld_issue_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        write_reg;
    logic [4:0]  sel_d1;
    logic [31:0] reg_d1;
    logic [31:0] rd_pending;
    logic        ld_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
        output mem_rvalid, mem_rdata,
        input  alu_ready, ld_issue_ready,
        input  write_reg, sel_d1, reg_d1, rd_pending, ld_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
        input  mem_rvalid, mem_rdata,
        output alu_ready, ld_issue_ready,
        output write_reg, sel_d1, reg_d1, rd_pending, ld_err
    );
endinterface

// File: rtl/rv32_writeback_unit.sv
// Register-file write-port driver. It merges in-order load responses with ALU results.
// ALU results that lose arbitration are parked in a FIFO so they are written in acceptance order.
module rv32_writeback_unit #(
    parameter int LDQ_DEPTH  = 4,
    parameter int ALUQ_DEPTH = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    rv32_writeback_unit_if.slave io_wb
);
    localparam int LAW = $clog2(LDQ_DEPTH);
    localparam int AAW = $clog2(ALUQ_DEPTH);
    localparam logic [LAW:0] LD_FULL  = (LAW + 1)'(LDQ_DEPTH);
    localparam logic [AAW:0] ALU_FULL = (AAW + 1)'(ALUQ_DEPTH);

    logic [4:0]  r_ldq_rd   [LDQ_DEPTH];
    logic [2:0]  r_ldq_f3   [LDQ_DEPTH];
    logic [1:0]  r_ldq_lo   [LDQ_DEPTH];
    logic [LAW-1:0] r_ld_wp, r_ld_rp;
    logic [LAW:0]   r_ld_cnt;

    logic [4:0]  r_aluq_rd   [ALUQ_DEPTH];
    logic [31:0] r_aluq_data [ALUQ_DEPTH];
    logic [AAW-1:0] r_alu_wp, r_alu_rp;
    logic [AAW:0]   r_alu_cnt;

    logic        r_write_reg;
    logic [4:0]  r_sel_d1;
    logic [31:0] r_reg_d1;
    logic        r_ld_err;

    logic        w_ld_ready, w_ld_push, w_ld_pop;
    logic        w_alu_ready, w_alu_acc, w_alu_enq, w_alu_deq;
    logic [4:0]  w_head_rd;
    logic [2:0]  w_head_f3;
    logic [1:0]  w_head_lo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic        w_win;
    logic [4:0]  w_win_rd;
    logic [31:0] w_win_data;
    logic [31:0] w_pend;

    assign w_ld_ready  = (r_ld_cnt < LD_FULL);
    assign w_ld_push   = io_wb.ld_issue_valid && w_ld_ready;
    assign w_ld_pop    = io_wb.mem_rvalid && (r_ld_cnt != '0);
    assign w_alu_ready = (r_alu_cnt < ALU_FULL);
    assign w_alu_acc   = io_wb.alu_valid && w_alu_ready;

    assign w_head_rd = r_ldq_rd[r_ld_rp];
    assign w_head_f3 = r_ldq_f3[r_ld_rp];
    assign w_head_lo = r_ldq_lo[r_ld_rp];
    assign w_byte    = io_wb.mem_rdata[{w_head_lo, 3'b000} +: 8];
    assign w_half    = io_wb.mem_rdata[{w_head_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = io_wb.mem_rdata;
        case (w_head_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'b0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'b0, w_half};
            default: w_ld_data = io_wb.mem_rdata;
        endcase
    end

    // Load response beats queued ALU entries, which in turn beat a fresh ALU result.
    always_comb begin
        w_win      = 1'b0;
        w_win_rd   = 5'd0;
        w_win_data = 32'd0;
        w_alu_enq  = 1'b0;
        w_alu_deq  = 1'b0;
        if (w_ld_pop) begin
            w_win      = 1'b1;
            w_win_rd   = w_head_rd;
            w_win_data = w_ld_data;
            w_alu_enq  = w_alu_acc;
        end else if (r_alu_cnt != '0) begin
            w_win      = 1'b1;
            w_win_rd   = r_aluq_rd[r_alu_rp];
            w_win_data = r_aluq_data[r_alu_rp];
            w_alu_deq  = 1'b1;
            w_alu_enq  = w_alu_acc;
        end else if (w_alu_acc) begin
            w_win      = 1'b1;
            w_win_rd   = io_wb.alu_rd;
            w_win_data = io_wb.alu_data;
        end
    end

    always_comb begin
        w_pend = 32'd0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if ((LAW + 1)'(i) < r_ld_cnt) w_pend[r_ldq_rd[r_ld_rp + LAW'(i)]] = 1'b1;
        end
        for (int i = 0; i < ALUQ_DEPTH; i++) begin
            if ((AAW + 1)'(i) < r_alu_cnt) w_pend[r_aluq_rd[r_alu_rp + AAW'(i)]] = 1'b1;
        end
        w_pend[0] = 1'b0;
    end

    // Queue storage needs no reset; occupancy counters define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_ld_push) begin
            r_ldq_rd[r_ld_wp] <= io_wb.ld_issue_rd;
            r_ldq_f3[r_ld_wp] <= io_wb.ld_issue_funct3;
            r_ldq_lo[r_ld_wp] <= io_wb.ld_issue_addr_lo;
        end
        if (w_alu_enq) begin
            r_aluq_rd[r_alu_wp]   <= io_wb.alu_rd;
            r_aluq_data[r_alu_wp] <= io_wb.alu_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ld_wp     <= '0;
            r_ld_rp     <= '0;
            r_ld_cnt    <= '0;
            r_alu_wp    <= '0;
            r_alu_rp    <= '0;
            r_alu_cnt   <= '0;
            r_write_reg <= 1'b0;
            r_sel_d1    <= 5'd0;
            r_reg_d1    <= 32'd0;
            r_ld_err    <= 1'b0;
        end else begin
            if (w_ld_push) r_ld_wp <= r_ld_wp + 1'b1;
            if (w_ld_pop)  r_ld_rp <= r_ld_rp + 1'b1;
            case ({w_ld_push, w_ld_pop})
                2'b10:   r_ld_cnt <= r_ld_cnt + 1'b1;
                2'b01:   r_ld_cnt <= r_ld_cnt - 1'b1;
                default: r_ld_cnt <= r_ld_cnt;
            endcase
            if (w_alu_enq) r_alu_wp <= r_alu_wp + 1'b1;
            if (w_alu_deq) r_alu_rp <= r_alu_rp + 1'b1;
            case ({w_alu_enq, w_alu_deq})
                2'b10:   r_alu_cnt <= r_alu_cnt + 1'b1;
                2'b01:   r_alu_cnt <= r_alu_cnt - 1'b1;
                default: r_alu_cnt <= r_alu_cnt;
            endcase
            r_write_reg <= w_win && (w_win_rd != 5'd0);
            r_sel_d1    <= w_win_rd;
            r_reg_d1    <= w_win_data;
            if (io_wb.mem_rvalid && (r_ld_cnt == '0)) r_ld_err <= 1'b1;
        end
    end

    assign io_wb.alu_ready      = w_alu_ready;
    assign io_wb.ld_issue_ready = w_ld_ready;
    assign io_wb.write_reg      = r_write_reg;
    assign io_wb.sel_d1         = r_sel_d1;
    assign io_wb.reg_d1         = r_reg_d1;
    assign io_wb.rd_pending     = w_pend;
    assign io_wb.ld_err         = r_ld_err;
endmodule

// File: tb/tb_rv32_writeback_unit.sv
// Bench for rv32_writeback_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the writeback rules.
module tb_rv32_writeback_unit;
    localparam int LDQ_D  = 4;
    localparam int ALUQ_D = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32_writeback_unit_if wb_if ();

    rv32_writeback_unit #(.LDQ_DEPTH(LDQ_D), .ALUQ_DEPTH(ALUQ_D)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_wb  (wb_if)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] lo;
    } ld_t;

    ld_t         m_ldq[$];
    logic [36:0] m_aluq[$];
    logic        m_err = 1'b0;
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic        e_alu_rdy, e_ld_rdy, o_alu_rdy, o_ld_rdy, m_alu_acc;

    logic [2:0]  ext_f3[3]  = '{3'b000, 3'b101, 3'b010};
    logic [31:0] ext_exp[3] = '{32'hFFFFFF80, 32'h00001180, 32'h11803344};

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'h000000FF;
        h = (w >> (16 * lo[1])) & 32'h0000FFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                          input logic lv, input logic [4:0] lrd, input logic [2:0] lf,
                          input logic [1:0] llo, input logic rv, input logic [31:0] rdat);
        wb_if.alu_valid        = av;
        wb_if.alu_rd           = ard;
        wb_if.alu_data         = ad;
        wb_if.ld_issue_valid   = lv;
        wb_if.ld_issue_rd      = lrd;
        wb_if.ld_issue_funct3  = lf;
        wb_if.ld_issue_addr_lo = llo;
        wb_if.mem_rvalid       = rv;
        wb_if.mem_rdata        = rdat;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock: sample readies mid-cycle, apply the writeback rules to the model,
    // then return #1 after the edge with the expected registered outputs.
    task automatic step();
        ld_t         e;
        logic [36:0] a;
        logic        win, ld_acc;
        logic [4:0]  wrd;
        logic [31:0] wd;
        @(negedge clk);
        o_alu_rdy = wb_if.alu_ready;
        o_ld_rdy  = wb_if.ld_issue_ready;
        e_alu_rdy = (m_aluq.size() < ALUQ_D);
        e_ld_rdy  = (m_ldq.size() < LDQ_D);
        win = 0; wrd = 0; wd = 0; m_alu_acc = 0;
        if (!rst_n) begin
            m_ldq.delete();
            m_aluq.delete();
            m_err = 0;
        end else begin
            m_alu_acc = wb_if.alu_valid && e_alu_rdy;
            ld_acc    = wb_if.ld_issue_valid && e_ld_rdy;
            if (wb_if.mem_rvalid && m_ldq.size() > 0) begin
                e   = m_ldq.pop_front();
                win = 1; wrd = e.rd; wd = ref_load(e.f3, e.lo, wb_if.mem_rdata);
                if (m_alu_acc) m_aluq.push_back({wb_if.alu_rd, wb_if.alu_data});
            end else begin
                if (wb_if.mem_rvalid) m_err = 1;
                if (m_aluq.size() > 0) begin
                    a   = m_aluq.pop_front();
                    win = 1; wrd = a[36:32]; wd = a[31:0];
                    if (m_alu_acc) m_aluq.push_back({wb_if.alu_rd, wb_if.alu_data});
                end else if (m_alu_acc) begin
                    win = 1; wrd = wb_if.alu_rd; wd = wb_if.alu_data;
                end
            end
            if (ld_acc) m_ldq.push_back({wb_if.ld_issue_rd, wb_if.ld_issue_funct3, wb_if.ld_issue_addr_lo});
        end
        e_we   = win && (wrd != 0);
        e_sel  = wrd;
        e_data = wd;
        e_pend = 0;
        foreach (m_ldq[i]) e_pend[m_ldq[i].rd] = 1'b1;
        foreach (m_aluq[i]) e_pend[m_aluq[i][36:32]] = 1'b1;
        e_pend[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_in();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        if (wb_if.write_reg !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb_if.write_reg); end
        checks++;
        if (wb_if.sel_d1 !== 5'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", wb_if.sel_d1); end
        checks++;
        if (wb_if.reg_d1 !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_if.reg_d1); end
        checks++;
        if (wb_if.ld_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", wb_if.ld_err); end
        checks++;
        if (wb_if.rd_pending !== 32'd0) begin failures++; $display("FAIL reset_pend got=%h exp=0", wb_if.rd_pending); end
        checks++;
        if (wb_if.alu_ready !== 1'b1 || wb_if.ld_issue_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b%b exp=11", wb_if.alu_ready, wb_if.ld_issue_ready);
        end
        checks++;
    endtask

    task automatic test_direct_alu();
        do_reset();
        set_in(1, 5, 32'h00001234, 0, 0, 0, 0, 0, 0);
        step();
        if (wb_if.write_reg !== 1'b1 || wb_if.sel_d1 !== 5'd5 || wb_if.reg_d1 !== 32'h00001234) begin
            failures++;
            $display("FAIL direct_alu got=%b/%0d/%h exp=1/5/00001234", wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1);
        end
        checks++;
        idle_in();
        step();
        if (wb_if.write_reg !== 1'b0) begin failures++; $display("FAIL direct_alu_pulse got=%b exp=0", wb_if.write_reg); end
        checks++;
    endtask

    task automatic test_load_extract();
        do_reset();
        for (int t = 0; t < 3; t++) begin
            set_in(0, 0, 0, 1, 7, ext_f3[t], 2'd2, 0, 0);
            step();
            idle_in();
            if (wb_if.rd_pending[7] !== 1'b1) begin failures++; $display("FAIL ext_pend_set t=%0d got=0 exp=1", t); end
            checks++;
            step();
            if (wb_if.rd_pending[7] !== 1'b1) begin failures++; $display("FAIL ext_pend_hold t=%0d got=0 exp=1", t); end
            checks++;
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h11803344);
            step();
            idle_in();
            if (wb_if.write_reg !== 1'b1 || wb_if.sel_d1 !== 5'd7 || wb_if.reg_d1 !== ext_exp[t]) begin
                failures++;
                $display("FAIL ext_data t=%0d got=%b/%0d/%h exp=1/7/%h", t, wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1, ext_exp[t]);
            end
            checks++;
            if (wb_if.reg_d1 !== e_data) begin failures++; $display("FAIL ext_model t=%0d got=%h exp=%h", t, wb_if.reg_d1, e_data); end
            checks++;
            if (wb_if.rd_pending[7] !== 1'b0) begin failures++; $display("FAIL ext_pend_clr t=%0d got=1 exp=0", t); end
            checks++;
        end
    endtask

    task automatic test_collision();
        do_reset();
        set_in(0, 0, 0, 1, 3, 3'b010, 0, 0, 0);
        step();
        set_in(1, 4, 32'hB, 0, 0, 0, 0, 1, 32'hA);
        step();
        idle_in();
        if (wb_if.write_reg !== 1'b1 || wb_if.sel_d1 !== 5'd3 || wb_if.reg_d1 !== 32'hA) begin
            failures++; $display("FAIL collide_load got=%b/%0d/%h exp=1/3/a", wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1);
        end
        checks++;
        if (wb_if.rd_pending !== 32'h10) begin failures++; $display("FAIL collide_pend got=%h exp=00000010", wb_if.rd_pending); end
        checks++;
        step();
        if (wb_if.write_reg !== 1'b1 || wb_if.sel_d1 !== 5'd4 || wb_if.reg_d1 !== 32'hB) begin
            failures++; $display("FAIL collide_alu got=%b/%0d/%h exp=1/4/b", wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_q[$];
        logic [4:0] got_q[$];
        int nrd, resp_left;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 0, 1, 5'(20 + k), 3'b010, 0, 0, 0);
            step();
        end
        idle_in();
        step();
        if (o_ld_rdy !== 1'b0 || o_ld_rdy !== e_ld_rdy) begin failures++; $display("FAIL bp_ld_ready got=%b exp=0", o_ld_rdy); end
        checks++;
        exp_q = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
        nrd = 8;
        resp_left = 4;
        for (int c = 0; c < 15; c++) begin
            set_in(nrd <= 12, 5'(nrd), 32'hA000 + nrd, 0, 0, 0, 0, resp_left > 0, 32'h1000 + c);
            step();
            if (m_alu_acc) nrd++;
            if (resp_left > 0) resp_left--;
            if (o_alu_rdy !== e_alu_rdy) begin failures++; $display("FAIL bp_alu_ready c=%0d got=%b exp=%b", c, o_alu_rdy, e_alu_rdy); end
            checks++;
            if (wb_if.write_reg !== e_we || (e_we && (wb_if.sel_d1 !== e_sel || wb_if.reg_d1 !== e_data))) begin
                failures++;
                $display("FAIL bp_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1, e_we, e_sel, e_data);
            end
            checks++;
            if (wb_if.write_reg === 1'b1 && wb_if.sel_d1 >= 5'd8 && wb_if.sel_d1 <= 5'd12) got_q.push_back(wb_if.sel_d1);
        end
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_drain_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        checks++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_order i=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
            checks++;
        end
        idle_in();
    endtask

    task automatic test_edge_cases();
        do_reset();
        set_in(1, 0, 32'h55, 0, 0, 0, 0, 0, 0);
        step();
        idle_in();
        if (wb_if.write_reg !== 1'b0) begin failures++; $display("FAIL x0_write got=%b exp=0", wb_if.write_reg); end
        checks++;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        step();
        idle_in();
        if (wb_if.write_reg !== 1'b0) begin failures++; $display("FAIL orphan_write got=%b exp=0", wb_if.write_reg); end
        checks++;
        if (wb_if.ld_err !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", wb_if.ld_err); end
        checks++;
        step();
        if (wb_if.ld_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", wb_if.ld_err); end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            set_in(0, 0, 0, 1, 5'(k), 3'b010, 0, 0, 0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1, 5'(9 + k), 32'h900 + k, k < 2, 5'(4 + k), 3'b010, 0, 1, 32'h77);
            step();
        end
        idle_in();
        if (wb_if.rd_pending !== e_pend || e_pend !== 32'h00000E30) begin
            failures++; $display("FAIL mid_pend got=%h exp=%h", wb_if.rd_pending, 32'h00000E30);
        end
        checks++;
        rst_n = 0;
        step();
        rst_n = 1;
        if (wb_if.write_reg !== 1'b0 || wb_if.sel_d1 !== 5'd0 || wb_if.reg_d1 !== 32'd0) begin
            failures++; $display("FAIL mid_rst_out got=%b/%0d/%h exp=0/0/0", wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1);
        end
        checks++;
        if (wb_if.rd_pending !== 32'd0 || wb_if.ld_err !== 1'b0) begin
            failures++; $display("FAIL mid_rst_state got=%h/%b exp=0/0", wb_if.rd_pending, wb_if.ld_err);
        end
        checks++;
        if (wb_if.alu_ready !== 1'b1 || wb_if.ld_issue_ready !== 1'b1) begin
            failures++; $display("FAIL mid_rst_ready got=%b%b exp=11", wb_if.alu_ready, wb_if.ld_issue_ready);
        end
        checks++;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        step();
        idle_in();
        if (wb_if.write_reg !== 1'b0 || wb_if.ld_err !== 1'b1) begin
            failures++; $display("FAIL mid_stale_resp got=%b/%b exp=0/1", wb_if.write_reg, wb_if.ld_err);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            set_in($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom);
            step();
            if (wb_if.write_reg !== e_we || (e_we && (wb_if.sel_d1 !== e_sel || wb_if.reg_d1 !== e_data))) begin
                failures++;
                $display("FAIL rand_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, wb_if.write_reg, wb_if.sel_d1, wb_if.reg_d1, e_we, e_sel, e_data);
            end
            checks++;
            if (wb_if.rd_pending !== e_pend) begin failures++; $display("FAIL rand_pend c=%0d got=%h exp=%h", c, wb_if.rd_pending, e_pend); end
            checks++;
            if (wb_if.ld_err !== m_err) begin failures++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, wb_if.ld_err, m_err); end
            checks++;
            if (o_alu_rdy !== e_alu_rdy || o_ld_rdy !== e_ld_rdy) begin
                failures++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, o_alu_rdy, o_ld_rdy, e_alu_rdy, e_ld_rdy);
            end
            checks++;
        end
        rst_n = 1;
        idle_in();
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        test_reset();
        test_direct_alu();
        test_load_extract();
        test_collision();
        test_backpressure();
        test_edge_cases();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
